// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Single-ported RAM arbiter between the instruction fetch path and the
//   datapath load/store unit. Every access walks IDLE -> DACC/IACC -> RESP.
//   The hit is asserted while the FSM is in RESP. Load data is registered,
//   so a back-to-back requestor gets one access every three cycles.
//
// Handshake: a requestor holds iREN or dREN/dWEN until it sees its hit.
//   The arbiter samples requests only in IDLE. The RAM keeps ramREN/ramWEN
//   high until the cycle it returns ram_ready, and ramload is valid in that
//   same cycle. The arbiter drops the enables at the edge where ram_ready
//   is sampled high.
//
// Ports:
//   CLK, nRST              clock; asynchronous active-low reset
//   iREN, iaddr            fetch request and address
//   iload, ihit            registered fetch data and one-cycle completion pulse
//   dREN, dWEN             data read/write request (both high means write)
//   daddr, dstore          data address and write data
//   dload, dhit            registered read data and one-cycle completion pulse
//   ramREN, ramWEN         registered RAM enables (never both high)
//   ramaddr, ramstore      registered RAM address and write data
//   ramload, ram_ready     RAM read data and access-complete strobe
//   busy                   high in any state other than IDLE
//   err                    sticky flag set when an access times out
module memory_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

  state_t              state, next_state;
  logic                fair;       // 1 after a data access: the next fetch goes first
  logic                is_write;   // direction of the latched data access
  logic [CNT_W-1:0]    cnt;        // cycles spent in the current access
  logic                d_req;
  logic                start_d, start_i, done, timed_out;
  logic [DATA_W-1:0]   load_val;

  assign d_req = dREN | dWEN;

  // Abort substitutes a recognisable pattern so software can see the failure.
  assign load_val = ram_ready ? ramload : DATA_W'(32'hBAD1BAD1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_d    = 1'b0;
    start_i    = 1'b0;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !fair) begin
          start_d    = 1'b1;
          next_state = DACC;
        end else if (iREN) begin
          start_i    = 1'b1;
          next_state = IACC;
        end else if (d_req) begin
          start_d    = 1'b1;
          next_state = DACC;
        end
      end
      DACC, IACC: begin
        // ram_ready in the final allowed cycle is a normal completion.
        if (ram_ready) begin
          done = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // cnt counts completed cycles, so this is the TIMEOUT-th access cycle.
          done      = 1'b1;
          timed_out = 1'b1;
        end
        if (done) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iload    <= '0;
      dload    <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      fair     <= 1'b0;
      is_write <= 1'b0;
      cnt      <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      busy <= (next_state != IDLE);

      if (start_d) begin
        ramaddr  <= daddr;
        ramstore <= dstore;
        is_write <= dWEN;
        ramWEN   <= dWEN;
        ramREN   <= ~dWEN;
        cnt      <= '0;
      end else if (start_i) begin
        ramaddr  <= iaddr;
        is_write <= 1'b0;
        ramWEN   <= 1'b0;
        ramREN   <= 1'b1;
        cnt      <= '0;
      end else if (state == DACC || state == IACC) begin
        cnt <= cnt + 1'b1;
      end

      if (done) begin
        ramREN <= 1'b0;
        ramWEN <= 1'b0;
        if (timed_out) err <= 1'b1;
        if (state == DACC) begin
          dhit <= 1'b1;
          fair <= 1'b1;
          if (!is_write) dload <= load_val;
        end else begin
          ihit  <= 1'b1;
          fair  <= 1'b0;
          iload <= load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with TIMEOUT=4. Inputs are driven and
// outputs are sampled 1ns after each rising edge.
module tb_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] iload;
  logic          ihit;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic [DW-1:0] dload;
  logic          dhit;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic          ram_ready = 1'b0;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({ihit, dhit, ramREN, ramWEN, busy, err} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {ihit, dhit, ramREN, ramWEN, busy, err}); end
    total++; if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {iload, dload, ramaddr, ramstore}); end
    step();
    step();
    nRST = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fetch();
    iREN = 1'b1; iaddr = 32'h40;
    step();
    total++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin bad++; $display("FAIL fetch_en_c1 got=%b%b exp=10", ramREN, ramWEN); end
    total++; if (ramaddr !== 32'h40) begin bad++; $display("FAIL fetch_addr got=%h exp=00000040", ramaddr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy got=%b exp=1", busy); end
    step();
    total++; if (ramREN !== 1'b1 || ihit !== 1'b0) begin bad++; $display("FAIL fetch_c2 got=ren%b hit%b exp=ren1 hit0", ramREN, ihit); end
    step();
    total++; if (ramREN !== 1'b1 || ihit !== 1'b0) begin bad++; $display("FAIL fetch_c3 got=ren%b hit%b exp=ren1 hit0", ramREN, ihit); end
    ram_ready = 1'b1; ramload = 32'h8C220004; iREN = 1'b0;
    step();
    ram_ready = 1'b0;
    total++; if (ihit !== 1'b1 || dhit !== 1'b0) begin bad++; $display("FAIL fetch_hit got=i%b d%b exp=i1 d0", ihit, dhit); end
    total++; if (iload !== 32'h8C220004) begin bad++; $display("FAIL fetch_iload got=%h exp=8c220004", iload); end
    total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL fetch_ren_drop got=%b exp=0", ramREN); end
    step();
    total++; if (ihit !== 1'b0 || dhit !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fetch_idle got=i%b d%b busy%b exp=000", ihit, dhit, busy); end
  endtask

  task automatic test_contention();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
    ram_ready = 1'b1; ramload = 32'h1234;
    step();
    total++; if (ramaddr !== 32'h100 || ramREN !== 1'b1) begin bad++; $display("FAIL cont_data_first got=addr%h ren%b exp=addr00000100 ren1", ramaddr, ramREN); end
    step();
    total++; if (dhit !== 1'b1 || ihit !== 1'b0) begin bad++; $display("FAIL cont_dhit got=d%b i%b exp=d1 i0", dhit, ihit); end
    total++; if (dload !== 32'h1234) begin bad++; $display("FAIL cont_dload got=%h exp=00001234", dload); end
    daddr = 32'h104; ramload = 32'h5678;
    step();
    step();
    total++; if (ramaddr !== 32'h44 || ramREN !== 1'b1) begin bad++; $display("FAIL cont_fetch_next got=addr%h ren%b exp=addr00000044 ren1", ramaddr, ramREN); end
    step();
    total++; if (ihit !== 1'b1 || dhit !== 1'b0) begin bad++; $display("FAIL cont_ihit got=i%b d%b exp=i1 d0", ihit, dhit); end
    total++; if (iload !== 32'h5678 || dload !== 32'h1234) begin bad++; $display("FAIL cont_loads got=i%h d%h exp=i00005678 d00001234", iload, dload); end
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
    step();
  endtask

  task automatic test_write();
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramload = 32'hFFFF0000;
    step();
    total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL wr_en got=wen%b ren%b exp=wen1 ren0", ramWEN, ramREN); end
    total++; if (ramstore !== 32'hDEADBEEF || ramaddr !== 32'h200) begin bad++; $display("FAIL wr_bus got=st%h a%h exp=stdeadbeef a00000200", ramstore, ramaddr); end
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0; dWEN = 1'b0; dREN = 1'b0;
    total++; if (dhit !== 1'b1 || ramWEN !== 1'b0) begin bad++; $display("FAIL wr_hit got=hit%b wen%b exp=hit1 wen0", dhit, ramWEN); end
    total++; if (dload !== 32'h1234) begin bad++; $display("FAIL wr_dload_kept got=%h exp=00001234", dload); end
    step();
    total++; if (dhit !== 1'b0) begin bad++; $display("FAIL wr_single_pulse got=%b exp=0", dhit); end
  endtask

  task automatic test_timeout();
    dREN = 1'b1; daddr = 32'h300; ram_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      total++; if (dhit !== 1'b0 || err !== 1'b0 || ramREN !== 1'b1) begin bad++; $display("FAIL to_wait_c%0d got=hit%b err%b ren%b exp=hit0 err0 ren1", c, dhit, err, ramREN); end
    end
    step();
    dREN = 1'b0;
    total++; if (dhit !== 1'b1 || err !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL to_abort got=hit%b err%b ren%b exp=hit1 err1 ren0", dhit, err, ramREN); end
    total++; if (dload !== 32'hBAD1BAD1) begin bad++; $display("FAIL to_dload got=%h exp=bad1bad1", dload); end
    step();
    // A fetch after the abort completes normally; err stays set.
    iREN = 1'b1; iaddr = 32'h80; ram_ready = 1'b1; ramload = 32'h11112222;
    step();
    iREN = 1'b0;
    step();
    ram_ready = 1'b0;
    total++; if (ihit !== 1'b1 || iload !== 32'h11112222 || err !== 1'b1) begin bad++; $display("FAIL to_after got=hit%b il%h err%b exp=hit1 il11112222 err1", ihit, iload, err); end
    step();
    // ram_ready in the last allowed cycle is a normal completion.
    dREN = 1'b1; daddr = 32'h304; ramload = 32'h0000ABCD;
    step();
    step();
    step();
    step();
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0; dREN = 1'b0;
    total++; if (dhit !== 1'b1 || dload !== 32'h0000ABCD) begin bad++; $display("FAIL to_race got=hit%b dl%h exp=hit1 dl0000abcd", dhit, dload); end
    step();
  endtask

  task automatic test_reset_mid();
    iREN = 1'b1; iaddr = 32'h90;
    step();
    total++; if (ramREN !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", ramREN); end
    #2;
    nRST = 1'b0;
    #1;
    total++; if ({ramREN, ramWEN, busy, err, ihit, dhit} !== 6'b0) begin bad++; $display("FAIL rst_mid_flags got=%b exp=000000", {ramREN, ramWEN, busy, err, ihit, dhit}); end
    total++; if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin bad++; $display("FAIL rst_mid_regs got=%h exp=0", {iload, dload, ramaddr, ramstore}); end
    step();
    nRST = 1'b1;
    step();
    total++; if (ramREN !== 1'b1 || ramaddr !== 32'h90) begin bad++; $display("FAIL rst_mid_refetch got=ren%b a%h exp=ren1 a00000090", ramREN, ramaddr); end
    ram_ready = 1'b1; ramload = 32'h77; iREN = 1'b0;
    step();
    ram_ready = 1'b0;
    total++; if (ihit !== 1'b1 || iload !== 32'h77) begin bad++; $display("FAIL rst_mid_hit got=hit%b il%h exp=hit1 il00000077", ihit, iload); end
    step();
  endtask

  task automatic test_back_to_back();
    ram_ready = 1'b1; ramload = 32'h1; iREN = 1'b1; iaddr = 32'hC0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 8) iREN = 1'b0;
      total++; if (ihit !== (k % 3 == 1)) begin bad++; $display("FAIL b2b_ihit k=%0d got=%b exp=%b", k, ihit, (k % 3 == 1)); end
      total++; if (busy !== (k % 3 != 2)) begin bad++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, (k % 3 != 2)); end
    end
    ram_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
